// File: rtl/axil_single_manager_if.sv
// AXI4-Lite channel bundle between a single-outstanding manager and a subordinate.
// The master modport is the manager's view; the slave modport is the subordinate's.
interface axil_single_manager_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot, input awready,
        output wvalid, wdata, wstrb, input wready,
        input bvalid, bresp, output bready,
        output arvalid, araddr, arprot, input arready,
        input rvalid, rdata, rresp, output rready
    );

    modport slave (
        input awvalid, awaddr, awprot, output awready,
        input wvalid, wdata, wstrb, output wready,
        output bvalid, bresp, input bready,
        input arvalid, araddr, arprot, output arready,
        output rvalid, rdata, rresp, input rready
    );
endinterface

// File: rtl/axil_single_manager.sv
// Single-outstanding AXI4-Lite manager: one command in, one AXI read or write out,
// one response back. A new command is accepted only after the previous response handshake.
//
// state        | meaning
// IDLE         | waiting for a command, cmd_ready high
// WR_ADDR_DATA | AWVALID/WVALID outstanding, each drops on its own handshake
// WR_RESP      | BREADY high, waiting for BVALID
// RD_ADDR      | ARVALID high, waiting for ARREADY
// RD_DATA      | RREADY high, waiting for RVALID
// RESP         | rsp_valid high with captured data, waiting for rsp_ready
module axil_single_manager #(
    parameter int C_AXI_ADDR_WIDTH = 4
) (
    input  logic                        M_AXI_ACLK,
    input  logic                        M_AXI_ARESETN,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_write,
    input  logic [C_AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]                 cmd_wdata,
    input  logic [3:0]                  cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [31:0]                 rsp_rdata,
    output logic [1:0]                  rsp_resp,
    output logic                        busy,
    axil_single_manager_if.master       m_axi
);
    localparam int C_AXI_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP
    } state_t;

    state_t state, state_nxt;

    logic [C_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                          write_q;
    logic                          aw_pend;
    logic                          w_pend;
    logic                          accept;

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (accept) state_nxt = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            // Both halves may complete in the same cycle or in either order.
            WR_ADDR_DATA: if ((!aw_pend || m_axi.awready) && (!w_pend || m_axi.wready))
                              state_nxt = WR_RESP;
            WR_RESP:      if (m_axi.bvalid) state_nxt = RESP;
            RD_ADDR:      if (m_axi.arready) state_nxt = RD_DATA;
            RD_DATA:      if (m_axi.rvalid) state_nxt = RESP;
            RESP:         if (rsp_ready) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready     = (state == IDLE) && M_AXI_ARESETN;
        busy          = (state != IDLE);
        rsp_valid     = (state == RESP);
        m_axi.bready  = (state == WR_RESP);
        m_axi.arvalid = (state == RD_ADDR);
        m_axi.rready  = (state == RD_DATA);
    end

    // AWVALID/WVALID come from flops so they never follow a READY combinationally.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            aw_pend   <= 1'b0;
            w_pend    <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                write_q <= cmd_write;
                aw_pend <= cmd_write;
                w_pend  <= cmd_write;
            end else begin
                if (aw_pend && m_axi.awready) aw_pend <= 1'b0;
                if (w_pend && m_axi.wready)   w_pend  <= 1'b0;
            end
            if (state == WR_RESP && m_axi.bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= m_axi.bresp;
            end
            if (state == RD_DATA && m_axi.rvalid) begin
                rsp_rdata <= m_axi.rdata;
                rsp_resp  <= m_axi.rresp;
            end
        end
    end

    assign m_axi.awvalid = aw_pend && write_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.wvalid  = w_pend && write_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
endmodule

// File: tb/tb_axil_single_manager.sv
// Directed bench for axil_single_manager with a small AXI-lite register subordinate
// (configurable READY stalls, response codes) and protocol monitors.
module tb_axil_single_manager;
    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;

    axil_single_manager_if #(.ADDR_WIDTH(4)) axi ();

    axil_single_manager #(.C_AXI_ADDR_WIDTH(4)) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESETN(rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_wdata    (cmd_wdata),
        .cmd_wstrb    (cmd_wstrb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_resp     (rsp_resp),
        .busy         (busy),
        .m_axi        (axi.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int errs  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // subordinate knobs (written by the stimulus only)
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic        b_hold = 1'b0;
    logic [1:0]  b_code = 2'b00, r_code = 2'b00;
    logic        r_use_ovr = 1'b0;
    logic [31:0] r_ovr = '0;

    // subordinate / monitor state (written by the subordinate process only)
    logic [31:0] mem [4];
    int          cyc = 0;
    int          awv_cnt = 0, wv_cnt = 0, arv_cnt = 0;
    int          viol = 0, out_w = 0, out_r = 0;
    int          w_hs_cyc = 0, br_rise_cyc = -1;
    int          aw_wait = 0, w_wait = 0, ar_wait = 0;
    logic        aw_got = 0, w_got = 0;
    logic [3:0]  l_awaddr, last_araddr;
    logic [31:0] l_wdata;
    logic [3:0]  l_wstrb;
    logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_bv = 0, p_br = 0;
    logic        p_arv = 0, p_arr = 0, p_rv = 0, p_rr = 0;
    logic [3:0]  p_awaddr = 0, p_araddr = 0;
    logic [31:0] p_wdata = 0;
    logic [3:0]  p_wstrb = 0;

    // Values seen at a falling edge hold through the next rising edge, so the
    // previous falling-edge sample tells which handshakes just completed.
    initial begin
        for (int i = 0; i < 4; i++) mem[i] = '0;
        {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
        axi.bresp = 2'b00; axi.rresp = 2'b00; axi.rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid} = '0;
                aw_got = 0; w_got = 0; out_w = 0; out_r = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
            end else begin
                if (p_awv && !p_awr && (!axi.awvalid || axi.awaddr != p_awaddr)) viol++;
                if (p_wv && !p_wr && (!axi.wvalid || axi.wdata != p_wdata || axi.wstrb != p_wstrb)) viol++;
                if (p_arv && !p_arr && (!axi.arvalid || axi.araddr != p_araddr)) viol++;
                if (p_bv && p_br) begin axi.bvalid = 1'b0; out_w--; end
                if (p_rv && p_rr) begin axi.rvalid = 1'b0; out_r--; end
                if (p_awv && p_awr) begin
                    if (out_w != 0) viol++;
                    out_w++; aw_got = 1; aw_wait = 0; l_awaddr = p_awaddr;
                end
                if (p_wv && p_wr) begin
                    w_got = 1; w_wait = 0; l_wdata = p_wdata; l_wstrb = p_wstrb; w_hs_cyc = cyc;
                end
                if (p_arv && p_arr) begin
                    if (out_r != 0) viol++;
                    out_r++; ar_wait = 0; last_araddr = p_araddr;
                    axi.rdata  = r_use_ovr ? r_ovr : mem[p_araddr[3:2]];
                    axi.rresp  = r_code;
                    axi.rvalid = 1'b1;
                end
                if (aw_got && w_got && !b_hold) begin
                    for (int b = 0; b < 4; b++)
                        if (l_wstrb[b]) mem[l_awaddr[3:2]][8*b +: 8] = l_wdata[8*b +: 8];
                    axi.bvalid = 1'b1; axi.bresp = b_code;
                    aw_got = 0; w_got = 0;
                end
                if (axi.bready && !p_br) br_rise_cyc = cyc;
                axi.awready = axi.awvalid && (aw_wait == aw_delay);
                if (axi.awvalid && aw_wait < aw_delay) aw_wait++;
                axi.wready = axi.wvalid && (w_wait == w_delay);
                if (axi.wvalid && w_wait < w_delay) w_wait++;
                axi.arready = axi.arvalid && (ar_wait == ar_delay);
                if (axi.arvalid && ar_wait < ar_delay) ar_wait++;
                if (axi.awvalid) awv_cnt++;
                if (axi.wvalid)  wv_cnt++;
                if (axi.arvalid) arv_cnt++;
            end
            p_awv = axi.awvalid; p_awr = axi.awready; p_awaddr = axi.awaddr;
            p_wv = axi.wvalid;   p_wr = axi.wready;   p_wdata = axi.wdata; p_wstrb = axi.wstrb;
            p_bv = axi.bvalid;   p_br = axi.bready;
            p_arv = axi.arvalid; p_arr = axi.arready; p_araddr = axi.araddr;
            p_rv = axi.rvalid;   p_rr = axi.rready;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one command; lat is the cycle index (cycle 1 = after acceptance) where rsp_valid is seen.
    task automatic run_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                           input logic [3:0] ws, input int hold, output int lat,
                           output logic [31:0] rd, output logic [1:0] rs, output int acc,
                           output logic held_ok);
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin tick(); n++; end
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        tick();
        acc = cyc;
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 60) begin tick(); lat++; end
        check("rsp_valid_seen", rsp_valid, 1);
        rd = rsp_rdata; rs = rsp_resp; held_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!rsp_valid || rsp_rdata != rd || rsp_resp != rs || cmd_ready || !busy) held_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    int          lat, acc1, acc2, a0, w0, r0;
    logic [31:0] rd;
    logic [1:0]  rs;
    logic        ok, seen;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy_rsp_valid", {busy, rsp_valid}, 0);
        check("rst_rsp_data", {rsp_rdata, rsp_resp}, 0);
        check("rst_axi_handshakes", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        rst_n = 1'b1;
        #1;
        check("release_cmd_ready", cmd_ready, 1);
        tick();

        // zero-wait write
        a0 = awv_cnt; w0 = wv_cnt;
        run_cmd(1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 0, lat, rd, rs, acc1, ok);
        check("wr_awvalid_cycles", awv_cnt - a0, 1);
        check("wr_wvalid_cycles", wv_cnt - w0, 1);
        check("wr_latency", lat, 3);
        check("wr_resp", rs, 2'b00);
        check("wr_rdata_zero", rd, 0);
        check("wr_mem", mem[1], 32'hDEADBEEF);
        check("awprot_arprot", {axi.awprot, axi.arprot}, 0);

        // read with two ARREADY stalls
        ar_delay = 2; r_use_ovr = 1'b1; r_ovr = 32'h12345678;
        r0 = arv_cnt;
        run_cmd(1'b0, 4'h8, 32'h0, 4'h0, 0, lat, rd, rs, acc1, ok);
        check("rd_arvalid_cycles", arv_cnt - r0, 3);
        check("rd_araddr", last_araddr, 4'h8);
        check("rd_rdata", rd, 32'h12345678);
        check("rd_resp", rs, 2'b00);
        check("rd_latency", lat, 5);
        ar_delay = 0;

        // WREADY two cycles after AWREADY
        w_delay = 2; a0 = awv_cnt; w0 = wv_cnt;
        run_cmd(1'b1, 4'hC, 32'hA5A55A5A, 4'hF, 0, lat, rd, rs, acc1, ok);
        check("split_awvalid_cycles", awv_cnt - a0, 1);
        check("split_wvalid_cycles", wv_cnt - w0, 3);
        check("split_bready_after_w", br_rise_cyc, w_hs_cyc);
        check("split_latency", lat, 5);
        check("split_mem", mem[3], 32'hA5A55A5A);
        w_delay = 0;

        // SLVERR read held in RESP by rsp_ready low
        r_code = 2'b10; r_ovr = 32'h0BADF00D;
        run_cmd(1'b0, 4'h4, 32'h0, 4'h0, 5, lat, rd, rs, acc1, ok);
        check("hold_stable", ok, 1);
        check("hold_resp", rs, 2'b10);
        check("hold_rdata", rd, 32'h0BADF00D);
        check("hold_latency", lat, 3);
        r_code = 2'b00; r_use_ovr = 1'b0;

        // reset while waiting in WR_RESP
        b_hold = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 32'h55555555; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("pre_rst_bready", axi.bready, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_axi_handshakes", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 0);
        check("midrst_busy_rsp_cmd", {busy, rsp_valid, cmd_ready}, 0);
        tick();
        rst_n = 1'b1; b_hold = 1'b0;
        #1;
        check("midrst_release_cmd_ready", cmd_ready, 1);
        seen = 1'b0;
        repeat (4) begin tick(); if (rsp_valid) seen = 1'b1; end
        check("midrst_no_rsp", seen, 0);

        // back-to-back write then read to 0x0 through the register model
        run_cmd(1'b1, 4'h0, 32'hCAFEF00D, 4'hF, 0, lat, rd, rs, acc1, ok);
        run_cmd(1'b0, 4'h0, 32'h0, 4'h0, 0, lat, rd, rs, acc2, ok);
        check("b2b_interval", acc2 - acc1, 4);
        check("b2b_readback", rd, 32'hCAFEF00D);
        run_cmd(1'b1, 4'h0, 32'h11223344, 4'h5, 0, lat, rd, rs, acc1, ok);
        run_cmd(1'b0, 4'h0, 32'h0, 4'h0, 0, lat, rd, rs, acc2, ok);
        check("strb_readback", rd, 32'hCA22F044);
        check("protocol_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/axil_single_manager.md
# axil_single_manager

Single-outstanding AXI4-Lite manager that turns a simple command/response request interface into AXI4-Lite read and write transactions. It sits directly upstream of the team's AXI-lite subordinate register block, driving its AW/W/B/AR/R channels. It is used by test harnesses and control logic that need one register access at a time. At most one transaction is in flight, so a downstream subordinate never sees more than one outstanding read or write.

## Interface
Parameters:
- C_AXI_ADDR_WIDTH, 4, AXI address width.
- C_AXI_DATA_WIDTH, 32, data width; fixed, localparam, not overridable.

Ports:
- M_AXI_ACLK  in  1  clock; all logic on the rising edge.
- M_AXI_ARESETN  in  1  reset; asynchronous, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  C_AXI_ADDR_WIDTH  target address.
- cmd_wdata / cmd_wstrb  in  32 / 4  write data and byte strobes; ignored for reads.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_rdata  out  32  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the completed transaction.
- busy  out  1  high from command acceptance until the response handshake.
- M_AXI_AWVALID/AWREADY/AWADDR/AWPROT  out/in/out/out  1/1/C_AXI_ADDR_WIDTH/3  write address channel.
- M_AXI_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/32/4  write data channel.
- M_AXI_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel.
- M_AXI_ARVALID/ARREADY/ARADDR/ARPROT  out/in/out/out  1/1/C_AXI_ADDR_WIDTH/3  read address channel.
- M_AXI_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/32/2  read data channel.

## Operation
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP. The state is registered.
- cmd_ready = (state == IDLE) && M_AXI_ARESETN.
- IDLE, cmd_valid && cmd_ready:
  - Latch addr, wdata, wstrb and write into command registers.
  - Go to WR_ADDR_DATA if write, otherwise RD_ADDR.
- WR_ADDR_DATA:
  - AWVALID and WVALID are registered and rise together.
  - Each falls independently on its own handshake.
  - When both handshakes have completed (same cycle or different cycles), go to WR_RESP.
- WR_RESP: BREADY = 1. On BVALID && BREADY, capture BRESP into rsp_resp, clear rsp_rdata to 0, and go to RESP.
- RD_ADDR: ARVALID = 1 until the ARREADY handshake, then go to RD_DATA.
- RD_DATA: RREADY = 1. On RVALID && RREADY, capture RDATA and RRESP, then go to RESP.
- RESP:
  - rsp_valid = 1 and rsp_rdata/rsp_resp are held stable.
  - On rsp_ready, go to IDLE.
- AWPROT = ARPROT = 3'b000 at all times.
- AWADDR/ARADDR/WDATA/WSTRB are driven from the command registers. They are stable while the corresponding VALID is high.
- A VALID is never deasserted before its handshake, and never depends combinationally on a READY.
- BREADY and RREADY are low in every state except WR_RESP and RD_DATA respectively.
- BVALID or RVALID arriving in any other state is ignored; the channel is not accepted.
- Non-OKAY responses (SLVERR 2'b10, DECERR 2'b11) are passed through unchanged, with no retry.

## Timing
- Reset asserted, asynchronously:
  - State goes to IDLE.
  - All M_AXI VALID and READY outputs are 0.
  - rsp_valid = 0, busy = 0, cmd_ready = 0.
  - rsp_rdata = 0, rsp_resp = 2'b00.
  - Command registers are cleared to 0.
- Reset released: cmd_ready = 1 in the first cycle.
- Reset mid-transaction: the transaction is abandoned, with no response and all channels idle. The subordinate is reset by the same signal.
- Minimum latency against a zero-wait subordinate (AWREADY/WREADY/ARREADY high, B/R valid one cycle after handshake):
  - Command accepted at edge 0.
  - Address/data VALID high in cycle 1, handshake at edge 1.
  - BREADY/RREADY in cycle 2, handshake at edge 2.
  - rsp_valid in cycle 3.
  - Throughput with rsp_ready held high: one transaction per 4 cycles.
- Backpressure:
  - Each stalled READY on AW, W or AR adds one cycle per stall.
  - rsp_ready low holds RESP indefinitely; cmd_ready stays 0 throughout.
- AWREADY and WREADY in different cycles: WR_RESP is entered the cycle after the later handshake.

## Test plan
- Write addr 0x4, data 0xDEADBEEF, strb 0xF, zero-wait subordinate, BRESP 00 -> AWVALID=WVALID=1 for exactly 1 cycle; rsp_valid in cycle 3; rsp_resp=00; rsp_rdata=0.
- Read addr 0x8, subordinate returns 0x12345678/OKAY after 2 wait cycles on ARREADY -> ARVALID high 3 cycles with ARADDR=0x8 stable; rsp_rdata=0x12345678.
- Write with WREADY 2 cycles after AWREADY -> AWVALID drops after its handshake while WVALID stays high; BREADY rises only after the W handshake.
- Read returning RRESP=2'b10 with rsp_ready held low 5 cycles -> rsp_valid held 5+ cycles with rdata/resp stable; cmd_ready=0 until handshake.
- Assert M_AXI_ARESETN low while in WR_RESP -> all VALID/READY outputs 0 with no clock edge needed; rsp_valid never asserts; cmd_ready=1 in the first cycle after release.
- Back-to-back write then read to 0x0, with cmd_valid held and rsp_ready=1, against the subordinate register block -> read returns the written value; no channel is ever seen with more than one outstanding transaction.
